// File: rtl/uart_rx_fsm.sv
// UART receive engine: synchronized rx line, oversampled mid-bit sampling, parity and stop checks.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote over the last three ticks at each sample point.
module uart_rx_fsm #(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    input  logic                     baud_tick,
    input  logic                     rx_en,
    input  logic [3:0]               data_bits,
    input  logic                     parity_en,
    input  logic                     parity_odd,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overrun_err,
    output logic                     busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                   state;
    logic                     rx_meta;
    logic                     rx_s;
    logic                     samp;
    logic [TW-1:0]            tick_cnt;
    logic [3:0]               bit_cnt;
    logic [3:0]               nbits_q;
    logic                     par_en_q;
    logic                     par_odd_q;
    logic                     par_err_n;
    logic                     par_exp;
    logic [3:0]               cfg_bits;
    logic [MAX_DATA_BITS-1:0] shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hist <= 2'b11;
        else if (baud_tick)
            hist <= {hist[0], rx_s};
    end
    assign samp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign samp = rx_s;
`endif

    always_comb begin
        cfg_bits = data_bits;
        if (data_bits < 4'd5 || data_bits > 4'd8)
            cfg_bits = 4'd8;
    end

    // Unused upper bits of shift_reg are zero, so a full-width XOR covers only the data bits.
    assign par_exp = (^shift_reg) ^ par_odd_q;
    assign busy    = (state != S_IDLE);

    // rx_valid/rx_ready: a word transfers in any cycle where both are high; rx_data and
    // the error flags hold steady while rx_valid is high and no transfer has happened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            nbits_q     <= 4'd8;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            par_err_n   <= 1'b0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (state != S_IDLE && !rx_en) begin
                state    <= S_IDLE;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (baud_tick) begin
                case (state)
                    S_IDLE: begin
                        tick_cnt <= '0;
                        if (rx_en && !rx_s)
                            state <= S_START;
                    end
                    S_START: begin
                        if (tick_cnt == HALF_M1) begin
                            tick_cnt <= '0;
                            if (samp) begin
                                state <= S_IDLE;
                            end else begin
                                state     <= S_DATA;
                                bit_cnt   <= '0;
                                shift_reg <= '0;
                                par_err_n <= 1'b0;
                                nbits_q   <= cfg_bits;
                                par_en_q  <= parity_en;
                                par_odd_q <= parity_odd;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            for (int i = 0; i < MAX_DATA_BITS; i++)
                                if (int'(bit_cnt) == i)
                                    shift_reg[i] <= samp;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt + 4'd1 == nbits_q)
                                state <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt  <= '0;
                            par_err_n <= (samp != par_exp);
                            state     <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            state    <= S_IDLE;
                            if (!rx_valid || rx_ready) begin
                                rx_data    <= shift_reg;
                                parity_err <= par_err_n;
                                frame_err  <= !samp;
                                rx_valid   <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: tick-aligned frame driver, accepted-word scoreboard, summary line.
`timescale 1ns/1ps
module tb_uart_rx_fsm;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       baud_tick;
    logic       rx_en;
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int         n_checks = 0;
    int         n_bad = 0;
    int         overrun_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_fsm #(.OVERSAMPLE(OS), .MAX_DATA_BITS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .baud_tick   (baud_tick),
        .rx_en       (rx_en),
        .data_bits   (data_bits),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && overrun_err)
            overrun_cnt++;
        if (rst_n && rx_valid && rx_ready) begin
            check_eq("sb_has_word", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
                check_eq("sb_word", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (!baud_tick);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (OS) wait_tick();
        #1;
    endtask

    // Drives start, data, optional parity, then returns just after the stop-bit sample edge.
    task automatic send_to_stop(input logic [7:0] d, input int n, input logic use_par,
                                input logic par_bit, input logic stop_bit);
        wait_tick();
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < n; i++)
            drive_bit(d[i]);
        if (use_par)
            drive_bit(par_bit);
        rx = stop_bit;
        repeat (OS / 2 + 1) wait_tick();
        #1;
    endtask

    task automatic idle_ticks(input int n);
        rx = 1'b1;
        repeat (n) wait_tick();
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        rx         = 1'b1;
        rx_en      = 1'b1;
        data_bits  = 4'd8;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        rx_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", 32'(rx_data), 32'h0);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_perr", 32'(parity_err), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_ovr", 32'(overrun_err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 8N1 0xA5
        exp_q.push_back(8'hA5);
        send_to_stop(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        check_eq("8n1_valid", 32'(rx_valid), 32'd1);
        check_eq("8n1_data", 32'(rx_data), 32'hA5);
        check_eq("8n1_perr", 32'(parity_err), 32'd0);
        check_eq("8n1_ferr", 32'(frame_err), 32'd0);
        check_eq("8n1_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_eq("8n1_valid_drop", 32'(rx_valid), 32'd0);
        idle_ticks(6);

        // 7E1 0x41: correct parity bit is 0
        data_bits = 4'd7;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        exp_q.push_back(8'h41);
        send_to_stop(8'h41, 7, 1'b1, 1'b1, 1'b1);
        check_eq("7e1_bad_data", 32'(rx_data), 32'h41);
        check_eq("7e1_bad_perr", 32'(parity_err), 32'd1);
        check_eq("7e1_bad_ferr", 32'(frame_err), 32'd0);
        idle_ticks(6);
        exp_q.push_back(8'h41);
        send_to_stop(8'h41, 7, 1'b1, 1'b0, 1'b1);
        check_eq("7e1_ok_valid", 32'(rx_valid), 32'd1);
        check_eq("7e1_ok_perr", 32'(parity_err), 32'd0);
        idle_ticks(6);

        // 5O1 0x15 (three ones, odd parity bit 0), stop bit driven low
        data_bits = 4'd5;
        parity_odd = 1'b1;
        exp_q.push_back(8'h15);
        send_to_stop(8'h15, 5, 1'b1, 1'b0, 1'b0);
        check_eq("5o1_data", 32'(rx_data), 32'h15);
        check_eq("5o1_ferr", 32'(frame_err), 32'd1);
        check_eq("5o1_perr", 32'(parity_err), 32'd0);
        idle_ticks(6);

        // False start: line low for 4 ticks only
        data_bits = 4'd8;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        wait_tick();
        #1;
        rx = 1'b0;
        repeat (4) wait_tick();
        #1;
        check_eq("glitch_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (12) wait_tick();
        #1;
        check_eq("glitch_busy_lo", 32'(busy), 32'd0);
        check_eq("glitch_no_valid", 32'(rx_valid), 32'd0);
        check_eq("glitch_held_ferr", 32'(frame_err), 32'd1);

        // Back-to-back frames with consumer stalled
        rx_ready = 1'b0;
        overrun_cnt = 0;
        exp_q.push_back(8'h11);
        send_to_stop(8'h11, 8, 1'b0, 1'b0, 1'b1);
        check_eq("b2b_first_valid", 32'(rx_valid), 32'd1);
        check_eq("b2b_first_data", 32'(rx_data), 32'h11);
        check_eq("b2b_first_ferr", 32'(frame_err), 32'd0);
        idle_ticks(6);
        send_to_stop(8'h22, 8, 1'b0, 1'b0, 1'b1);
        check_eq("b2b_ovr_pulse", 32'(overrun_err), 32'd1);
        check_eq("b2b_held_data", 32'(rx_data), 32'h11);
        check_eq("b2b_held_valid", 32'(rx_valid), 32'd1);
        @(posedge clk);
        #1;
        check_eq("b2b_ovr_clear", 32'(overrun_err), 32'd0);
        idle_ticks(6);
        check_eq("b2b_ovr_count", 32'(overrun_cnt), 32'd1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("b2b_valid_drop", 32'(rx_valid), 32'd0);
        check_eq("b2b_data_kept", 32'(rx_data), 32'h11);

        // rx_en abort in DATA
        wait_tick();
        #1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check_eq("abort_busy_hi", 32'(busy), 32'd1);
        rx_en = 1'b0;
        rx = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy_lo", 32'(busy), 32'd0);
        check_eq("abort_no_valid", 32'(rx_valid), 32'd0);
        check_eq("abort_data_kept", 32'(rx_data), 32'h11);
        rx_en = 1'b1;
        idle_ticks(4);

        // Asynchronous reset mid-frame
        wait_tick();
        #1;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_data", 32'(rx_data), 32'h0);
        check_eq("mrst_valid", 32'(rx_valid), 32'd0);
        check_eq("mrst_perr", 32'(parity_err), 32'd0);
        check_eq("mrst_ferr", 32'(frame_err), 32'd0);
        check_eq("mrst_ovr", 32'(overrun_err), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        exp_q.push_back(8'h3C);
        send_to_stop(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        check_eq("post_valid", 32'(rx_valid), 32'd1);
        check_eq("post_data", 32'(rx_data), 32'h3C);
        check_eq("post_ferr", 32'(frame_err), 32'd0);
        idle_ticks(6);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
UART receive engine, the counterpart of the transmit FSM. It deserializes the line using a 16x oversampling tick (OVERSAMPLE ticks per bit) and mid-bit sampling. It checks optional parity and the stop bit, then presents the received word on a valid/ready handshake to the CSR/FIFO side. It sits between the pad-side rx line and the RX data register.

Parameters:
OVERSAMPLE, 16, baud ticks per bit; even, >=8
MAX_DATA_BITS, 8, width of rx_data

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rx  in  1  serial line, asynchronous to clk; idle high
baud_tick  in  1  single-cycle pulse at OVERSAMPLE x baud rate
rx_en  in  1  receiver enable
data_bits  in  4  data bits per frame; legal 5..8, other values treated as 8
parity_en  in  1  frame carries a parity bit
parity_odd  in  1  1=odd parity, 0=even
rx_data  out  MAX_DATA_BITS  received word, LSB first on line, right-aligned, upper bits 0
rx_valid  out  1  rx_data/parity_err/frame_err valid
rx_ready  in  1  consumer accepts word
parity_err  out  1  parity mismatch for word held in rx_data
frame_err  out  1  stop bit sampled 0 for word held in rx_data
overrun_err  out  1  one-cycle pulse: completed frame dropped
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; rx sync flops reset to 1; counters 0.
- rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s.
- tick_cnt advances only on baud_tick. The sample point is tick_cnt==OVERSAMPLE/2-1 in START and tick_cnt==OVERSAMPLE-1 in DATA/PARITY/STOP. At the sample point tick_cnt clears to 0.
- IDLE: on baud_tick with rx_s==0 and rx_en=1, go to START with tick_cnt=0.
- START: at the sample point, rx_s==1 (glitch/false start) -> IDLE with no output. rx_s==0 -> DATA with bit_cnt=0.
- DATA: at each sample point, shift rx_s into shift register position bit_cnt and increment bit_cnt. When bit_cnt reaches data_bits: go to PARITY if parity_en, else STOP.
- PARITY: at the sample point, compute expected = XOR(data bits) XOR parity_odd. parity_err_n = (rx_s != expected). Go to STOP.
- STOP: at the sample point, frame_err_n = (rx_s==0). Go to IDLE, so back-to-back frames are accepted; the next start can be detected on the next tick.
- Completion, in the clk cycle after the stop sample point:
  - If rx_valid==0 or rx_ready==1 in that same cycle: load rx_data, parity_err and frame_err; assert rx_valid.
  - Otherwise, pulse overrun_err for 1 cycle and keep the old word and flags.
- Handshake:
  - rx_valid stays high until the cycle with rx_valid & rx_ready, then drops next cycle unless a new word loads in that same cycle.
  - rx_data and flags are stable while rx_valid=1.
- rx_en=0 in any non-IDLE state aborts to IDLE next clk. No valid, no errors; the held word is unaffected.
- Configuration inputs are sampled at the START->DATA transition and held for the frame. Changes mid-frame have no effect until the next frame.
- Latency: rx_valid rises 1 clk after the baud_tick at the stop-bit midpoint.
- Asynchronous reset mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN:
- Defined: each bit value is the 2-of-3 majority of rx_s captured on the last three ticks up to and including the sample point. This applies to the START validity check as well.
- Undefined: single sample at the sample point.
- Timing and state flow are identical either way.

Test Plan:
- 8N1, byte 0xA5, rx_ready=1 -> rx_valid pulse with rx_data=0xA5, parity_err=0, frame_err=0, busy low 1 clk after stop midpoint.
- 7E1, data 0x41, parity bit 1 (wrong) -> rx_data=0x41, parity_err=1; with parity bit 0 -> parity_err=0.
- 5O1, data 0x15, stop bit driven 0 -> rx_data=0x15, frame_err=1.
- Line low for 4 ticks then high -> no rx_valid, FSM back to IDLE, busy pulses then clears.
- Two back-to-back 8N1 frames 0x11 then 0x22, rx_ready=0 -> rx_data stays 0x11, overrun_err pulses once; then rx_ready=1 -> valid drops.
- rx_en deasserted mid DATA, then assert rst_n=0 mid frame -> no rx_valid, all outputs 0; next frame 0x3C is received correctly.
